// File: rtl/dec_counter_pkg.sv
// Purpose : shared constants for the decade counter slice (segment patterns,
//           default modulus) plus a digit-to-pattern lookup function.
// Latency : n/a (constants and a pure function); no flow control.
// Contents: DEC_MODULUS, DEC_WIDTH, SEG_0..SEG_9, SEG_BLANK, seg_pattern().
package dec_counter_pkg;

   // Default counter geometry: a decade counter fits in 4 bits.
   localparam int DEC_MODULUS = 10;
   localparam int DEC_WIDTH   = 4;

   // Active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Active-high pattern for a 4-bit digit; anything above 9 is blank.
   function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage : dec_counter_pkg

// File: rtl/dec_counter_seg7_decoder.sv
// Purpose : seven-segment decoder for one BCD digit, optional output inversion.
// Latency : purely combinational, zero cycles; no flow control.
// Ports   : digit_i [3:0] digit to show, seg_o [6:0] pattern {g,f,e,d,c,b,a}.
module seg7_decoder
   import dec_counter_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   logic [6:0] seg_hi;

   assign seg_hi = seg_pattern(digit_i);

   // Common-anode displays sink current to light a segment, so every bit
   // (including the blank pattern) is inverted.
   assign seg_o = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule : seg7_decoder

// File: rtl/dec_counter.sv
// Purpose : modulo-MODULUS up-counter with terminal-count flag and 7-seg decode.
// Latency : count updates every rising clk edge; tc/seg follow count combinationally.
// Ports   : clk, reset (async active-low), count [WIDTH-1:0], tc, seg [6:0];
//           free running, no enable and no backpressure -- cascade through tc.
module dec_counter
   import dec_counter_pkg::*;
#(
   parameter int WIDTH          = DEC_WIDTH,
   parameter int MODULUS        = DEC_MODULUS,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic [6:0]       seg
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [3:0]       digit;

   // A single ">= LAST" test both wraps the normal sequence and pulls any
   // out-of-range value (e.g. after an upset) straight back to zero.
   always_comb begin
      count_d = count_q + WIDTH'(1);
      if (count_q >= LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Outputs come straight from the register so downstream sees no
   // next-state glitches.
   assign count = count_q;
   assign tc    = (count_q == LAST);

   // Values beyond 9 must blank the display even when WIDTH > 4, so they
   // are mapped to a code the decoder treats as blank before truncation.
   assign digit = (int'(count_q) > 9) ? 4'hF : 4'(count_q);

   seg7_decoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
   ) u_seg7_decoder (
      .digit_i(digit),
      .seg_o  (seg)
   );

endmodule : dec_counter

// File: tb/tb_dec_counter.sv
// Purpose : self-checking bench for dec_counter against a behavioural model.
// Latency : expects count to move on each rising edge, tc/seg combinational.
// Ports   : drives clk/reset into an active-high and an active-low instance.
module tb_dec_counter;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] count_h, count_l;
   logic       tc_h, tc_l;
   logic [6:0] seg_h, seg_l;

   int vectors    = 0;
   int miscompares = 0;
   int mdl        = 0;   // model of the current count value
   int tc_pulses  = 0;

   // Display patterns for digits 0..9 written out from the datasheet table.
   int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   dec_counter #(.WIDTH(4), .MODULUS(10), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .reset(reset), .count(count_h), .tc(tc_h), .seg(seg_h)
   );

   dec_counter #(.WIDTH(4), .MODULUS(10), .SEG_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .reset(reset), .count(count_l), .tc(tc_l), .seg(seg_l)
   );

   always #10 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_seg(input int v);
      return (v >= 0 && v <= 9) ? seg_tab[v] : 0;
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, " count"},    count_h, mdl);
      check_eq({tag, " tc"},       tc_h, (mdl == 9));
      check_eq({tag, " seg"},      seg_h, exp_seg(mdl));
      check_eq({tag, " count_al"}, count_l, mdl);
      check_eq({tag, " tc_al"},    tc_l, (mdl == 9));
      check_eq({tag, " seg_al"},   seg_l, (~exp_seg(mdl)) & 'h7F);
   endtask

   // One clock: apply the counting rule at the rising edge, check at the
   // falling edge where outputs are stable.
   task automatic step(input string tag);
      @(posedge clk);
      if (reset == 1'b0)  mdl = 0;
      else if (mdl >= 9)  mdl = 0;
      else                mdl = mdl + 1;
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      int n;
      int r;

      // Power-up held in reset with the clock running.
      repeat (3) step("por");

      // Release between edges, then 12 clocks: 1..9,0,1,2.
      #2 reset = 1'b1;
      for (int i = 0; i < 12; i++) step("run12");

      // Reach count 6 (bounded), then reset asynchronously mid-cycle.
      for (int i = 0; i < 20 && mdl != 6; i++) step("to6");
      check_eq("reach6", count_h, 6);
      #3 reset = 1'b0;
      mdl = 0;
      #1 check_all("async_rst");

      // Hold reset over several edges; count must stay 0.
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) step("hold");
      #3 reset = 1'b1;
      step("resume");
      check_eq("resume_is1", count_h, 1);

      // Fresh release, then 100 free-running clocks with tc position checks.
      #2 reset = 1'b0;
      mdl = 0;
      step("pre100");
      #3 reset = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         step("free");
         if (tc_h) tc_pulses++;
         check_eq("tc_pos", tc_h, (i % 10 == 9));
         if (count_h > 9) check_eq("range", count_h, 9);
      end
      check_eq("tc_pulses", tc_pulses, 10);

      // Random reset pulses landing at random points between edges.
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 15);
         if (reset && r == 0) begin
            #($urandom_range(1, 8)) reset = 1'b0;
            mdl = 0;
            #1 check_all("rand_async");
         end else if (!reset && r < 8) begin
            #($urandom_range(1, 8)) reset = 1'b1;
         end
         step("rand");
      end

      // Illegal state: load 12 into both counters, expect blank/no tc, then wrap to 0.
      #2 reset = 1'b1;
      step("pre_ill");
      force dut.count_q    = 4'd12;
      force dut_al.count_q = 4'd12;
      #1;
      release dut.count_q;
      release dut_al.count_q;
      mdl = 12;
      #1 check_all("illegal");
      step("recover");
      check_eq("recover0", count_h, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_dec_counter
